// File: rtl/spi_minion_adapter.sv
// Bridges SPI minion frames {val_wrt, val_rd, payload} to buffered receive/send
// val/rdy streams, and reports read data plus receive-space status in outgoing frames.
module spi_minion_adapter #(
  parameter int nbits       = 34,
  parameter int num_entries = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic [nbits-1:0] push_msg,
  input  logic             pull_en,
  output logic [nbits-1:0] pull_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic [nbits-3:0] recv_msg,
  input  logic             send_val,
  output logic             send_rdy,
  input  logic [nbits-3:0] send_msg,
  output logic             overflow
);

  localparam int DW = nbits - 2;
  localparam int PW = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int CW = $clog2(num_entries + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(num_entries);
  localparam logic [PW-1:0] LAST_PTR = PW'(num_entries - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [DW-1:0] recv_mem [num_entries];
  logic [DW-1:0] send_mem [num_entries];

  logic [PW-1:0] recv_head_q, recv_head_d, recv_tail_q, recv_tail_d;
  logic [PW-1:0] send_head_q, send_head_d, send_tail_q, send_tail_d;
  logic [CW-1:0] recv_cnt_q, recv_cnt_d, send_cnt_q, send_cnt_d;
  logic          rd_pending_q, rd_pending_d;
  logic          overflow_q, overflow_d;

  logic val_wrt, val_rd;
  logic recv_full, recv_empty, send_full, send_empty;
  logic recv_enq, recv_deq, recv_drop;
  logic send_enq, send_deq, pull_val;

  assign val_wrt    = push_msg[nbits-1];
  assign val_rd     = push_msg[nbits-2];
  assign recv_full  = (recv_cnt_q == FULL_CNT);
  assign recv_empty = (recv_cnt_q == '0);
  assign send_full  = (send_cnt_q == FULL_CNT);
  assign send_empty = (send_cnt_q == '0);

  // Fullness is judged on the pre-dequeue count, so a same-cycle dequeue never frees a slot.
  assign recv_enq  = push_en & val_wrt & ~recv_full;
  assign recv_drop = push_en & val_wrt & recv_full;
  assign recv_deq  = ~recv_empty & recv_rdy;
  assign send_enq  = send_val & ~send_full;
  assign pull_val  = rd_pending_q & ~send_empty;
  assign send_deq  = pull_en & pull_val;

  always_comb begin
    recv_head_d  = recv_deq ? ptr_inc(recv_head_q) : recv_head_q;
    recv_tail_d  = recv_enq ? ptr_inc(recv_tail_q) : recv_tail_q;
    send_head_d  = send_deq ? ptr_inc(send_head_q) : send_head_q;
    send_tail_d  = send_enq ? ptr_inc(send_tail_q) : send_tail_q;
    recv_cnt_d   = recv_cnt_q;
    send_cnt_d   = send_cnt_q;
    if (recv_enq && !recv_deq) recv_cnt_d = recv_cnt_q + CW'(1);
    if (!recv_enq && recv_deq) recv_cnt_d = recv_cnt_q - CW'(1);
    if (send_enq && !send_deq) send_cnt_d = send_cnt_q + CW'(1);
    if (!send_enq && send_deq) send_cnt_d = send_cnt_q - CW'(1);
    // A new read request in a back-to-back frame outranks the pull's clear.
    rd_pending_d = rd_pending_q;
    if (send_deq)          rd_pending_d = 1'b0;
    if (push_en && val_rd) rd_pending_d = 1'b1;
    overflow_d   = overflow_q | recv_drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recv_head_q  <= '0;
      recv_tail_q  <= '0;
      recv_cnt_q   <= '0;
      send_head_q  <= '0;
      send_tail_q  <= '0;
      send_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      recv_head_q  <= recv_head_d;
      recv_tail_q  <= recv_tail_d;
      recv_cnt_q   <= recv_cnt_d;
      send_head_q  <= send_head_d;
      send_tail_q  <= send_tail_d;
      send_cnt_q   <= send_cnt_d;
      rd_pending_q <= rd_pending_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are gated by the counts.
  always_ff @(posedge clk) begin
    if (recv_enq) recv_mem[recv_tail_q] <= push_msg[DW-1:0];
    if (send_enq) send_mem[send_tail_q] <= send_msg;
  end

  assign recv_val = ~recv_empty;
  assign recv_msg = recv_empty ? '0 : recv_mem[recv_head_q];
  assign send_rdy = ~send_full;
  assign overflow = overflow_q;
  assign pull_msg = {pull_val, ~recv_full, pull_val ? send_mem[send_head_q] : {DW{1'b0}}};

endmodule

// File: doc/spi_minion_adapter.md
Name: spi_minion_adapter

Overview:
Downstream/upstream companion to the SPI minion. It consumes the minion's push_en/push_msg frame after chip-select rises and supplies pull_msg when chip-select falls. Each SPI frame is {val_wrt, val_rd, payload}. The block converts frames into two buffered val/rdy streams toward the core:
- receive: SPI to core
- send: core to SPI

It also reports buffer status back to the SPI master in the top two bits of the next outgoing frame.

Parameters:
nbits, 34, SPI frame width; payload is nbits-2 bits.
num_entries, 2, depth of each internal FIFO (>=1).

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
push_en  in  1  one-cycle strobe: SPI frame received.
push_msg  in  nbits  frame received: [nbits-1]=val_wrt, [nbits-2]=val_rd, [nbits-3:0]=payload.
pull_en  in  1  one-cycle strobe: minion is loading pull_msg this cycle.
pull_msg  out  nbits  outgoing frame: [nbits-1]=val, [nbits-2]=spc, [nbits-3:0]=data.
recv_val  out  1  receive FIFO non-empty.
recv_rdy  in  1  core accepts recv_msg.
recv_msg  out  nbits-2  head of receive FIFO.
send_val  in  1  core offers send_msg.
send_rdy  out  1  send FIFO not full.
send_msg  in  nbits-2  payload to return to master.
overflow  out  1  sticky: a write frame was dropped because the receive FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs empty; rd_pending=0; overflow=0.
  - Outputs: recv_val=0, send_rdy=1, recv_msg=0.
  - pull_msg = {0, 1, 0}.
  - A reset mid-transaction discards all buffered data and any pending read; nothing is replayed.
- Both FIFOs:
  - Circular buffers with head/tail pointers wrapping at num_entries-1 back to 0.
  - Count width is clog2(num_entries+1).
  - No bypass: data enqueued in cycle t is visible at the head no earlier than t+1.
- Receive path:
  - On push_en with val_wrt=1 and the receive FIFO not full, enqueue the payload; recv_val=1 from the next cycle.
  - On push_en with val_wrt=1 and the FIFO full, drop the payload and set overflow=1. overflow stays set until reset.
  - Dequeue when recv_val & recv_rdy.
  - Enqueue and dequeue in the same cycle when full:
    - The enqueue is evaluated against the pre-dequeue count, so the frame is dropped.
    - The dequeue completes.
  - Enqueue and dequeue in the same cycle when partially full: both occur; count unchanged.
- Send path:
  - send_rdy = ~full. Enqueue when send_val & send_rdy.
  - A simultaneous pull dequeue does not make room for an enqueue in that same cycle.
- Read request:
  - On push_en with val_rd=1, set rd_pending=1.
  - A val_rd=0 frame does not clear rd_pending.
- Pull (combinational, valid whenever pull_en may be asserted):
  - val = rd_pending & send FIFO non-empty.
  - spc = receive FIFO not full.
  - data = send FIFO head if val, else 0.
  - On pull_en with val=1: dequeue the send FIFO and clear rd_pending in the same cycle.
  - On pull_en with val=0: no state change.
- push_en and pull_en in the same cycle (back-to-back frames):
  - Push effects and pull effects both apply.
  - pull_msg uses the pre-push state.
  - The push's val_rd sets rd_pending after the pull's clear, so the new request survives.
- Payload widths:
  - payload/data = nbits-2 bits, passed through unmodified.
  - Frames narrower than 3 bits are unsupported.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles, then release -> recv_val=0, send_rdy=1, overflow=0, pull_msg=34'h1_0000_0000 (spc=1, val=0).
- Single write: push_en with push_msg={1,0,32'hDEADBEEF} -> next cycle recv_val=1, recv_msg=32'hDEADBEEF; recv_rdy=1 for one cycle -> recv_val=0.
- Receive overflow: with num_entries=2, three write frames 1, 2, 3 and recv_rdy=0 -> overflow=1, spc=0; draining yields 1 then 2 only.
- Read handshake: send_val with 32'h12345678, then push frame {0,1,0}, then pull_en -> pull_msg={1,1,32'h12345678}; send FIFO empties; a second pull_en gives val=0.
- Simultaneous push/pull: rd_pending=1, send FIFO holds A and B; pull_en and push_en({0,1,x}) in the same cycle -> pull returns A, rd_pending stays 1; next pull returns B.
- Reset mid-operation: with both FIFOs full, assert reset for one cycle -> FIFOs empty, overflow=0, send_rdy=1 immediately (asynchronous).
